eth_rx_ctrl: RTL and testbench

RMII receive-side control and deframer for the 50 MHz Clk domain; the receive counterpart of the TX control FSM. Detects preamble/SFD on Rxd/Crs_Dv, assembles LSB-first dibits into bytes, and tracks frame fields. It qualifies bytes for the downstream RX CRC checker and RX FIFO, and reports a one-cycle good/bad verdict per frame with length and error code.

---
 rtl/eth_rx_ctrl.sv | 136 +++++++++++++
 tb/tb_eth_rx_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_ctrl.sv
// eth_rx_ctrl: RMII receive deframer (preamble/SFD detect, LSB-first byte assembly, per-frame verdict)
module eth_rx_ctrl #(
    parameter int pMin_Preamble_Cnt = 12,
    parameter int pMin_Frame_Len    = 64,
    parameter int pMax_Frame_Len    = 1518
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [1:0]  Rxd,
    input  logic        Crs_Dv,
    input  logic        Crc_Ok,
    input  logic        Fifo_Full,
    output logic [3:0]  Rx_Ctrl_FSM_State,
    output logic [7:0]  Rx_Byte,
    output logic        Rx_Byte_Vld,
    output logic        Crc_En,
    output logic [10:0] Frame_Len,
    output logic        Frame_Good,
    output logic        Frame_Bad,
    output logic [2:0]  Err_Code
);
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        PREAMBLE  = 4'd1,
        DEST_ADDR = 4'd3,
        SRC_ADDR  = 4'd4,
        LEN_TYPE  = 4'd5,
        DATA      = 4'd6,
        DONE      = 4'd8,
        DROP      = 4'd9
    } state_t;

    localparam logic [4:0]  MIN_PRE = 5'(pMin_Preamble_Cnt);
    localparam logic [10:0] MIN_LEN = 11'(pMin_Frame_Len);
    localparam logic [10:0] MAX_LEN = 11'(pMax_Frame_Len);
    localparam logic [10:0] MAX_SAT = 11'(pMax_Frame_Len + 1);

    state_t      state;
    logic [4:0]  pre_cnt;
    logic [1:0]  dib_idx;
    logic [7:0]  sh;
    logic [10:0] byte_cnt;
    logic [10:0] nb;
    logic        ovf;
    logic        aln;
    logic        giant;
    logic [2:0]  err;

    assign Rx_Ctrl_FSM_State = state;

    always_comb begin
        nb  = byte_cnt == MAX_SAT ? byte_cnt : byte_cnt + 11'd1;
        err = ovf ? 3'd1 : aln ? 3'd2 : byte_cnt < MIN_LEN ? 3'd3 : giant ? 3'd4 : !Crc_Ok ? 3'd5 : 3'd0;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= IDLE;
            pre_cnt     <= '0;
            dib_idx     <= '0;
            sh          <= '0;
            byte_cnt    <= '0;
            ovf         <= 1'b0;
            aln         <= 1'b0;
            giant       <= 1'b0;
            Rx_Byte     <= '0;
            Rx_Byte_Vld <= 1'b0;
            Crc_En      <= 1'b0;
            Frame_Len   <= '0;
            Frame_Good  <= 1'b0;
            Frame_Bad   <= 1'b0;
            Err_Code    <= '0;
        end else begin
            Rx_Byte_Vld <= 1'b0;
            Frame_Good  <= 1'b0;
            Frame_Bad   <= 1'b0;
            case (state)
                IDLE: begin
                    if (Crs_Dv && Rxd == 2'b01) begin
                        state   <= PREAMBLE;
                        pre_cnt <= 5'd1;
                    end else if (Crs_Dv && Rxd != 2'b00) begin
                        state <= DROP;
                    end
                end
                PREAMBLE: begin
                    if (Crs_Dv && Rxd == 2'b01) begin
                        pre_cnt <= pre_cnt == 5'd31 ? pre_cnt : pre_cnt + 5'd1;
                    end else if (Crs_Dv && Rxd == 2'b11 && pre_cnt >= MIN_PRE) begin
                        state    <= DEST_ADDR;
                        dib_idx  <= '0;
                        byte_cnt <= '0;
                        ovf      <= 1'b0;
                        aln      <= 1'b0;
                        giant    <= 1'b0;
                        Crc_En   <= 1'b1;
                    end else begin
                        state <= DROP;
                    end
                end
                DEST_ADDR, SRC_ADDR, LEN_TYPE, DATA: begin
                    if (!Crs_Dv) begin
                        state  <= DONE;
                        Crc_En <= 1'b0;
                        aln    <= dib_idx != 2'd0;
                    end else begin
                        dib_idx <= dib_idx + 2'd1;
                        sh      <= {Rxd, sh[7:2]};
                        if (dib_idx == 2'd3) begin
                            // once past the maximum length bytes are counted but not forwarded
                            byte_cnt    <= nb;
                            Rx_Byte     <= {Rxd, sh[7:2]};
                            Rx_Byte_Vld <= byte_cnt < MAX_LEN;
                            giant       <= giant | (byte_cnt >= MAX_LEN);
                            ovf         <= ovf | Fifo_Full;
                            state       <= (state == DEST_ADDR && nb == 11'd6)  ? SRC_ADDR :
                                           (state == SRC_ADDR  && nb == 11'd12) ? LEN_TYPE :
                                           (state == LEN_TYPE  && nb == 11'd14) ? DATA : state;
                        end
                    end
                end
                DONE: begin
                    Frame_Len  <= byte_cnt;
                    Err_Code   <= err;
                    Frame_Good <= err == 3'd0;
                    Frame_Bad  <= err != 3'd0;
                    state      <= IDLE;
                end
                DROP: begin
                    if (!Crs_Dv) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_rx_ctrl.sv
// tb_eth_rx_ctrl: scoreboard bench for eth_rx_ctrl with directed frames
module tb_eth_rx_ctrl;
    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [1:0]  Rxd = 2'b00;
    logic        Crs_Dv = 1'b0;
    logic        Crc_Ok = 1'b0;
    logic        Fifo_Full = 1'b0;
    logic [3:0]  Rx_Ctrl_FSM_State;
    logic [7:0]  Rx_Byte;
    logic        Rx_Byte_Vld;
    logic        Crc_En;
    logic [10:0] Frame_Len;
    logic        Frame_Good;
    logic        Frame_Bad;
    logic [2:0]  Err_Code;

    eth_rx_ctrl dut (
        .Clk(Clk), .Rst(Rst), .Rxd(Rxd), .Crs_Dv(Crs_Dv), .Crc_Ok(Crc_Ok), .Fifo_Full(Fifo_Full),
        .Rx_Ctrl_FSM_State(Rx_Ctrl_FSM_State), .Rx_Byte(Rx_Byte), .Rx_Byte_Vld(Rx_Byte_Vld),
        .Crc_En(Crc_En), .Frame_Len(Frame_Len), .Frame_Good(Frame_Good), .Frame_Bad(Frame_Bad),
        .Err_Code(Err_Code)
    );

    always #10 Clk = ~Clk;

    typedef struct {
        logic good;
        int   code;
        int   len;
    } verdict_t;

    logic [7:0] exp_b[$];
    verdict_t   exp_v[$];
    int         st_seen[$];
    int         exp_seq[7] = '{1, 3, 4, 5, 6, 8, 0};
    logic       rec = 1'b0;
    int         prev_st = 0;
    int         tests = 0;
    int         fails = 0;
    verdict_t   mv;
    logic [7:0] mb;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] frame_byte(input int i);
        return i < 6 ? 8'hFF : i == 6 ? 8'h02 : i < 11 ? 8'h00 : i == 11 ? 8'h01 :
               i == 12 ? 8'h08 : i == 13 ? 8'h00 : 8'(i * 7 + 3);
    endfunction

    task automatic dib(input logic [1:0] d, input logic ff);
        @(negedge Clk);
        Crs_Dv = 1'b1;
        Rxd = d;
        Fifo_Full = ff;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge Clk);
            Crs_Dv = 1'b0;
            Rxd = 2'b00;
            Fifo_Full = 1'b0;
        end
    endtask

    task automatic queues_empty(input string tag);
        chk({tag, "_bytes_left"}, exp_b.size(), 0);
        chk({tag, "_verdicts_left"}, exp_v.size(), 0);
    endtask

    // pre x 01 + SFD, nbytes whole bytes, then `partial` dibits of the next byte
    task automatic frame(input int pre, input int nbytes, input int partial, input logic crc,
                         input int ff_idx, input logic vgood, input int vcode, input int vlen);
        logic [7:0] b;
        Crc_Ok = crc;
        repeat (pre) dib(2'b01, 1'b0);
        dib(2'b11, 1'b0);
        for (int i = 0; i < nbytes; i++) begin
            b = frame_byte(i);
            if (i < 1518) exp_b.push_back(b);
            for (int k = 0; k < 4; k++) dib(b[2*k +: 2], i == ff_idx);
        end
        b = frame_byte(nbytes);
        for (int k = 0; k < partial; k++) dib(b[2*k +: 2], 1'b0);
        exp_v.push_back('{vgood, vcode, vlen});
        idle_cycles(6);
    endtask

    always @(negedge Clk) begin
        if (!Rst) begin
            if (rec && int'(Rx_Ctrl_FSM_State) != prev_st) st_seen.push_back(int'(Rx_Ctrl_FSM_State));
            prev_st = int'(Rx_Ctrl_FSM_State);
            if (Rx_Byte_Vld) begin
                if (exp_b.size() == 0) chk("unexpected_rx_byte_vld", 1, 0);
                else begin
                    mb = exp_b.pop_front();
                    chk("rx_byte", int'(Rx_Byte), int'(mb));
                end
            end
            if (Frame_Good || Frame_Bad) begin
                chk("good_and_bad_exclusive", int'(Frame_Good & Frame_Bad), 0);
                if (exp_v.size() == 0) chk("unexpected_verdict", 1, 0);
                else begin
                    mv = exp_v.pop_front();
                    chk("frame_good", int'(Frame_Good), int'(mv.good));
                    chk("err_code", int'(Err_Code), mv.code);
                    chk("frame_len", int'(Frame_Len), mv.len);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge Clk);
        chk("reset_state", int'(Rx_Ctrl_FSM_State), 0);
        chk("reset_vld", int'(Rx_Byte_Vld), 0);
        chk("reset_crc_en", int'(Crc_En), 0);
        chk("reset_len", int'(Frame_Len), 0);
        chk("reset_verdict", int'({Frame_Good, Frame_Bad, Err_Code}), 0);
        Rst = 1'b0;
        idle_cycles(2);

        rec = 1'b1;
        frame(31, 64, 0, 1'b1, -1, 1'b1, 0, 64);
        rec = 1'b0;
        chk("state_seq_len", st_seen.size(), 7);
        for (int i = 0; i < 7 && i < st_seen.size(); i++) chk("state_seq", st_seen[i], exp_seq[i]);
        queues_empty("good");

        frame(31, 64, 0, 1'b0, -1, 1'b0, 5, 64);
        queues_empty("crc");
        frame(12, 40, 0, 1'b1, -1, 1'b0, 3, 40);
        queues_empty("runt");
        frame(12, 1600, 0, 1'b1, -1, 1'b0, 4, 1519);
        queues_empty("giant");
        frame(12, 69, 2, 1'b1, -1, 1'b0, 2, 69);
        queues_empty("align");
        frame(12, 69, 2, 1'b1, 9, 1'b0, 1, 69);
        queues_empty("overflow");

        repeat (5) dib(2'b01, 1'b0);
        dib(2'b11, 1'b0);
        @(posedge Clk);
        #1 chk("short_preamble_drop", int'(Rx_Ctrl_FSM_State), 9);
        repeat (8) dib(2'b10, 1'b0);
        idle_cycles(4);
        chk("drop_back_idle", int'(Rx_Ctrl_FSM_State), 0);
        queues_empty("drop");

        Crc_Ok = 1'b1;
        repeat (12) dib(2'b01, 1'b0);
        dib(2'b11, 1'b0);
        for (int i = 0; i < 20; i++) begin
            exp_b.push_back(frame_byte(i));
            for (int k = 0; k < 4; k++) dib(frame_byte(i) >> (2 * k), 1'b0);
        end
        dib(2'b01, 1'b0);
        chk("pre_reset_in_data", int'(Rx_Ctrl_FSM_State), 6);
        #5 Rst = 1'b1;
        #1;
        chk("rst_state", int'(Rx_Ctrl_FSM_State), 0);
        chk("rst_crc_en", int'(Crc_En), 0);
        chk("rst_byte", int'({Rx_Byte, Rx_Byte_Vld}), 0);
        chk("rst_len", int'(Frame_Len), 0);
        chk("rst_verdict", int'({Frame_Good, Frame_Bad, Err_Code}), 0);
        Crs_Dv = 1'b0;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        idle_cycles(6);
        queues_empty("reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
